// File: rtl/int_array_ctrl.sv
// int_array_ctrl: sequencer for a ROWS x COLS integer systolic array (clear, skewed compute, drain).
// Optional busy-cycle counter enabled by defining INT_ARRAY_CTRL_PERF_EN; otherwise perf_cycles is tied to 0.
module int_array_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 8,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               start_err,
    output logic               pe_sel,
    output logic [ROWS-1:0]    a_rd_en,
    output logic [COLS-1:0]    b_rd_en,
    output logic               res_valid,
    output logic [RW-1:0]      res_row,
    output logic [31:0]        perf_cycles
);
    // wide enough for the longest compute phase, k_len_max + ROWS + COLS - 2, without wrapping
    localparam int CW = $clog2((2 ** K_WIDTH) + ROWS + COLS);

    typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [K_WIDTH-1:0]   k_q, k_d;
    logic [CW-1:0]        last;
    logic                 run;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_err_q, start_err_d;
    logic                 pe_sel_q, pe_sel_d;
    logic [ROWS-1:0]      a_rd_en_q, a_rd_en_d;
    logic [COLS-1:0]      b_rd_en_q, b_rd_en_d;
    logic                 res_valid_q, res_valid_d;
    logic [RW-1:0]        res_row_q, res_row_d;

    assign last = CW'(k_q) + CW'(ROWS + COLS - 2);
    assign run  = state_q inside {CLEAR, COMPUTE, DRAIN};

    // next state, phase counter and the output values the next state implies
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start && k_len != '0) begin
                    k_d     = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = COMPUTE;
                cnt_d   = '0;
            end
            COMPUTE: begin
                state_d = (cnt_q == last) ? DRAIN : COMPUTE;
                cnt_d   = (cnt_q == last) ? CW'(ROWS - 1) : cnt_q + 1'b1;
            end
            DRAIN: begin
                state_d = (cnt_q == '0) ? DONE : DRAIN;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (abort && run) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        start_err_d = (state_q == IDLE) && start && (k_len == '0);
        busy_d      = state_d inside {CLEAR, COMPUTE, DRAIN};
        done_d      = state_d == DONE;
        pe_sel_d    = state_d == COMPUTE;
        res_valid_d = state_d == DRAIN;
        res_row_d   = res_valid_d ? cnt_d[RW-1:0] : '0;
        for (int r = 0; r < ROWS; r++)
            a_rd_en_d[r] = pe_sel_d && (cnt_d >= CW'(r)) && (cnt_d < CW'(r) + CW'(k_d));
        for (int j = 0; j < COLS; j++)
            b_rd_en_d[j] = pe_sel_d && (cnt_d >= CW'(j)) && (cnt_d < CW'(j) + CW'(k_d));
    end

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            pe_sel_q    <= 1'b0;
            a_rd_en_q   <= '0;
            b_rd_en_q   <= '0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            pe_sel_q    <= pe_sel_d;
            a_rd_en_q   <= a_rd_en_d;
            b_rd_en_q   <= b_rd_en_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;
    assign pe_sel    = pe_sel_q;
    assign a_rd_en   = a_rd_en_q;
    assign b_rd_en   = b_rd_en_q;
    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;

`ifdef INT_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_cnt_q, perf_q;

    // count busy cycles of the running job and publish the total as the job enters DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= run ? perf_cnt_q + 32'd1 : '0;
            if (state_q == DRAIN && state_d == DONE)
                perf_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_int_array_ctrl.sv
// tb_int_array_ctrl: directed and randomized checks of int_array_ctrl against a job-level timing model.
module tb_int_array_ctrl;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KW = 8;
    localparam int RW = 2;
    localparam int VW = 4 + R + C + 1 + RW + 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          abort = 1'b0;
    logic          busy, done, start_err, pe_sel, res_valid;
    logic [R-1:0]  a_rd_en;
    logic [C-1:0]  b_rd_en;
    logic [RW-1:0] res_row;
    logic [31:0]   perf_cycles;

    int n_cmp = 0;
    int n_fail = 0;

    int_array_ctrl #(.ROWS(R), .COLS(C), .K_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done), .start_err(start_err), .pe_sel(pe_sel),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .res_valid(res_valid),
        .res_row(res_row), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // job-level model: m_act while a job runs, m_t = cycles since the job was accepted
    bit          m_act, m_dn, m_err;
    int          m_t, m_k;
    logic [31:0] m_perf;

    function automatic int job_len(int k);
        return 1 + (k + R + C - 1) + R;
    endfunction

    task automatic model_update();
        if (!rst) begin
            m_act = 0; m_dn = 0; m_err = 0; m_t = 0; m_k = 0; m_perf = '0;
        end else begin
            m_err = 0;
            if (m_dn) m_dn = 0;
            else if (m_act) begin
                if (abort) m_act = 0;
                else if (m_t == job_len(m_k) - 1) begin
                    m_act = 0;
                    m_dn = 1;
`ifdef INT_ARRAY_CTRL_PERF_EN
                    m_perf = 32'(job_len(m_k));
`endif
                end else m_t++;
            end else if (start) begin
                if (k_len == '0) m_err = 1;
                else begin m_act = 1; m_t = 0; m_k = int'(k_len); end
            end
        end
    endtask

    function automatic logic [VW-1:0] expv();
        logic pe, rv;
        logic [R-1:0] a;
        logic [C-1:0] b;
        logic [RW-1:0] row;
        int c;
        c = m_t - 1;
        pe = m_act && m_t >= 1 && m_t <= m_k + R + C - 1;
        for (int r = 0; r < R; r++) a[r] = pe && r <= c && c < r + m_k;
        for (int j = 0; j < C; j++) b[j] = pe && j <= c && c < j + m_k;
        rv = m_act && m_t >= m_k + R + C;
        row = rv ? RW'(R - 1 - (m_t - (m_k + R + C))) : '0;
        return {m_act, m_dn, m_err, pe, a, b, rv, row, m_perf};
    endfunction

    function automatic logic [VW-1:0] obsv();
        return {busy, done, start_err, pe_sel, a_rd_en, b_rd_en, res_valid, res_row, perf_cycles};
    endfunction

    task automatic step(input logic r, input logic s, input int k, input logic a);
        rst = r; start = s; k_len = KW'(k); abort = a;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 3, 1);
        step(0, 0, 0, 0);
        n_cmp++;
        if (obsv() !== '0) begin n_fail++; $display("FAIL reset_state: got %h exp 0", obsv()); end
        n_cmp++;
        if (obsv() !== expv()) begin n_fail++; $display("FAIL reset_model: got %h exp %h", obsv(), expv()); end
    endtask

    task automatic test_basic_job();
        int nbusy = 0, ndone = 0;
        logic [31:0] a2 = '0, b3 = '0;
        logic [7:0] rows = '0;
        step(1, 1, 3, 0);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL basic i=%0d: got %h exp %h", i, obsv(), expv()); end
            nbusy += int'(busy);
            ndone += int'(done);
            a2[i] = a_rd_en[2];
            b3[i] = b_rd_en[3];
            if (res_valid) rows = {rows[5:0], res_row};
            step(1, 0, int'($urandom_range(0, 255)), 0);
        end
        n_cmp++;
        if (nbusy !== 15) begin n_fail++; $display("FAIL basic_busy_len: got %0d exp 15", nbusy); end
        n_cmp++;
        if (ndone !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d exp 1", ndone); end
        n_cmp++;
        if (a2 !== 32'h38) begin n_fail++; $display("FAIL basic_a2_mask: got %h exp 38", a2); end
        n_cmp++;
        if (b3 !== 32'h70) begin n_fail++; $display("FAIL basic_b3_mask: got %h exp 70", b3); end
        n_cmp++;
        if (rows !== 8'hE4) begin n_fail++; $display("FAIL basic_res_rows: got %h exp e4", rows); end
`ifdef INT_ARRAY_CTRL_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'd15) begin n_fail++; $display("FAIL basic_perf: got %0d exp 15", perf_cycles); end
`endif
    endtask

    task automatic test_kzero();
        step(1, 1, 0, 0);
        n_cmp++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL kzero_err: got err=%b busy=%b exp 1 0", start_err, busy); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, i == 1);
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL kzero i=%0d: got %h exp %h", i, obsv(), expv()); end
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        step(1, 1, 3, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        n_cmp++;
        if (pe_sel !== 1'b1 || a_rd_en !== 4'b1000) begin n_fail++; $display("FAIL abort_pre c=5: got pe=%b a=%b exp 1 1000", pe_sel, a_rd_en); end
        step(1, 1, 5, 1);
        n_cmp++;
        if (obsv() !== expv() || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %h exp %h", obsv(), expv()); end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            ndone += int'(done);
        end
        n_cmp++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_done: got %0d exp 0", ndone); end
    endtask

    task automatic test_reset_drain();
        int nbusy = 0;
        step(1, 1, 3, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        n_cmp++;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rstdrain_in_drain: got %b exp 1", res_valid); end
        step(0, 0, 0, 0);
        n_cmp++;
        if (obsv() !== '0) begin n_fail++; $display("FAIL rstdrain_reset: got %h exp 0", obsv()); end
        step(1, 1, 3, 0);
        for (int i = 0; i < 18; i++) begin
            nbusy += int'(busy);
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL rstdrain_job i=%0d: got %h exp %h", i, obsv(), expv()); end
            step(1, 0, 0, 0);
        end
        n_cmp++;
        if (nbusy !== 15) begin n_fail++; $display("FAIL rstdrain_busy_len: got %0d exp 15", nbusy); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0, first_done = -1, second_busy = -1;
        step(1, 1, 3, 0);
        for (int i = 0; i < 34; i++) begin
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL b2b i=%0d: got %h exp %h", i, obsv(), expv()); end
            ndone += int'(done);
            if (done && first_done < 0) first_done = i;
            if (busy && first_done >= 0 && second_busy < 0) second_busy = i;
            step(1, 1, 3, 0);
        end
        n_cmp++;
        if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d exp 2", ndone); end
        n_cmp++;
        if (first_done !== 15 || second_busy !== 17) begin n_fail++; $display("FAIL b2b_gap: got done@%0d busy@%0d exp 15 17", first_done, second_busy); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_kmax();
        int nbusy = 0, ndone = 0;
        step(1, 1, 255, 0);
        for (int i = 0; i < 272; i++) begin
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL kmax i=%0d: got %h exp %h", i, obsv(), expv()); end
            nbusy += int'(busy);
            ndone += int'(done);
            step(1, 0, 0, 0);
        end
        n_cmp++;
        if (nbusy !== 267 || ndone !== 1) begin n_fail++; $display("FAIL kmax_len: got busy=%0d done=%0d exp 267 1", nbusy, ndone); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            step($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0, k, $urandom_range(0, 59) == 0);
            n_cmp++;
            if (obsv() !== expv()) begin n_fail++; $display("FAIL random i=%0d: got %h exp %h", i, obsv(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_kzero();
        test_abort();
        test_reset_drain();
        test_back_to_back();
        test_kmax();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/int_array_ctrl.md
INT_ARRAY_CTRL -- requirements
Module: int_array_ctrl

Interface
REQ-001 Parameter ROWS, default 4: PE rows in the systolic array.
REQ-002 Parameter COLS, default 4: PE columns in the systolic array.
REQ-003 Parameter K_WIDTH, default 8: width of the reduction-length field.
REQ-004 The block SHALL have the following ports:
- clk  in  1: sole clock, rising edge.
- rst  in  1: synchronous, active-low reset.
- start  in  1: job request, sampled only in IDLE.
- k_len  in  K_WIDTH: reduction length, sampled with start.
- abort  in  1: synchronous job cancel.
- busy  out  1: a job is in progress.
- done  out  1: one-cycle pulse at job completion.
- start_err  out  1: one-cycle pulse on a rejected start.
- pe_sel  out  1: broadcast to every PE fsm_out_select_in (0 = load/shift, 1 = accumulate).
- a_rd_en  out  ROWS: per-row left-operand feed enable.
- b_rd_en  out  COLS: per-column top-operand feed enable.
- res_valid  out  1: array bottom outputs carry results.
- res_row  out  clog2(ROWS): row index of the current result beat.
- perf_cycles  out  32: busy-cycle count of the last job.

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, COMPUTE, DRAIN and DONE, each registered.
REQ-006 In IDLE, start=1 with k_len!=0 SHALL latch k_len and enter CLEAR on the next cycle.
REQ-007 In IDLE, start=1 with k_len==0 SHALL pulse start_err for one cycle and remain in IDLE.
REQ-008 CLEAR SHALL last exactly 1 cycle with pe_sel=0 and all rd_en=0 (feeders drive zero), zeroing the accumulators; then COMPUTE.
REQ-009 COMPUTE SHALL last exactly k_len+ROWS+COLS-1 cycles with pe_sel=1, counted by c = 0 .. k_len+ROWS+COLS-2.
REQ-010 a_rd_en[r] SHALL be 1 only when r <= c < r+k_len, skewing the left operands.
REQ-011 b_rd_en[j] SHALL be 1 only when j <= c < j+k_len, skewing the top operands.
REQ-012 Outside COMPUTE, all rd_en bits SHALL be 0.
REQ-013 DRAIN SHALL last exactly ROWS cycles with pe_sel=0 and res_valid=1.
REQ-014 During DRAIN, res_row SHALL count down from ROWS-1 to 0, one per cycle (bottom row emerges first).
REQ-015 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-016 done SHALL be high only in DONE.
REQ-017 busy SHALL be 1 in CLEAR, COMPUTE and DRAIN, and 0 in IDLE and DONE.
REQ-018 start SHALL be ignored in every state other than IDLE, with no error pulse.
REQ-019 abort=1 in CLEAR, COMPUTE or DRAIN SHALL enter IDLE on the next cycle: no done, res_valid and rd_en drop to 0, pe_sel=0.
REQ-020 abort SHALL take priority over any same-cycle state transition.
REQ-021 abort in IDLE or DONE SHALL have no effect.
REQ-022 A k_len at its maximum value (2^K_WIDTH-1) SHALL complete correctly; the internal cycle counter SHALL be wide enough that it never wraps.
REQ-023 Changes to k_len while busy SHALL NOT affect the running job.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE and clear the latched k_len and all counters, including mid-job.
REQ-025 After reset, the outputs SHALL be: busy=0, done=0, start_err=0, pe_sel=0, a_rd_en=0, b_rd_en=0, res_valid=0, res_row=0, perf_cycles=0.

Configuration
REQ-026 With macro INT_ARRAY_CTRL_PERF_EN defined, perf_cycles SHALL count busy cycles of the current job.
REQ-027 With INT_ARRAY_CTRL_PERF_EN defined, perf_cycles SHALL be updated on entry to DONE and hold until the next DONE or reset.
REQ-028 With INT_ARRAY_CTRL_PERF_EN defined, perf_cycles SHALL NOT be updated by an aborted job.
REQ-029 Without INT_ARRAY_CTRL_PERF_EN, perf_cycles SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-030 ROWS=COLS=4, start with k_len=3: busy for exactly 15 cycles (1+10+4), then done for 1 cycle; with PERF_EN, perf_cycles=15.
REQ-031 Same job: a_rd_en[2] high only at c=2..4 and b_rd_en[3] high only at c=3..5; res_row sequence 3,2,1,0.
REQ-032 start with k_len=0 in IDLE -> start_err pulses once and busy stays 0.
REQ-033 abort at c=5 of a k_len=3 job -> IDLE next cycle, done never asserts, perf_cycles unchanged.
REQ-034 rst=0 during DRAIN -> all outputs at their reset values after that edge; a new start afterwards runs a full 15-cycle job.
REQ-035 start held high through a whole job -> a second job begins on the cycle after DONE (IDLE lasts 1 cycle).
